// File: rtl/poly_pkg.sv
// Shared constants for the iterative Taylor (e^x) evaluator.
// Fixed-point formats: x and coefficients Q2.14, accumulator Q7.25.
// ALIGN_SHIFT moves a Q2.14 coefficient onto the Q7.25 accumulator grid.
package poly_pkg;

  localparam int FRAC_IN     = 14;
  localparam int FRAC_OUT    = 25;
  localparam int ALIGN_SHIFT = FRAC_OUT - FRAC_IN;

  // Default Taylor coefficients 1, 1, 1/2, 1/6, 1/24, 1/120 in Q2.14
  localparam logic [15:0] DEF_A0 = 16'h4000;
  localparam logic [15:0] DEF_A1 = 16'h4000;
  localparam logic [15:0] DEF_A2 = 16'h2000;
  localparam logic [15:0] DEF_A3 = 16'h0AAA;
  localparam logic [15:0] DEF_A4 = 16'h02AA;
  localparam logic [15:0] DEF_A5 = 16'h0088;

  // Index of the final multiply-add step (A0)
  localparam logic [2:0] CNT_LAST = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/horner_step.sv
// One Horner multiply-add: r = ((a * x) >> FRAC_IN) + (c << ALIGN_SHIFT), mod 2^WIDTHOUT.
// Latency: purely combinational.
// Backpressure: none, the owning FSM sequences it.
// Ports: a  - accumulator, Q7.25
//        x  - input operand, Q2.14
//        c  - coefficient, Q2.14
//        r  - next accumulator, Q7.25 (truncating product, wrapping sum)
module horner_step
  import poly_pkg::*;
#(
  parameter int WIDTHIN  = 16,
  parameter int WIDTHOUT = 32
) (
  input  logic [WIDTHOUT-1:0] a,
  input  logic [WIDTHIN-1:0]  x,
  input  logic [WIDTHIN-1:0]  c,
  output logic [WIDTHOUT-1:0] r
);

  localparam int PW = WIDTHOUT + WIDTHIN;

  logic [PW-1:0] p;
  logic          unused_bits;

  assign p = {{WIDTHIN{1'b0}}, a} * {{WIDTHOUT{1'b0}}, x};

  // Drop the low FRAC_IN fraction bits (truncation) and anything above the
  // accumulator width (silent wrap).
  assign r = p[FRAC_IN +: WIDTHOUT]
           + ({{(WIDTHOUT-WIDTHIN){1'b0}}, c} << ALIGN_SHIFT);

  assign unused_bits = ^{p[PW-1:FRAC_IN+WIDTHOUT], p[FRAC_IN-1:0]};

endmodule

// File: rtl/horner_seq_ctrl.sv
// Iterative degree-5 Taylor (e^x) evaluator using one shared Horner step, 1 result / 7 cycles.
// Latency: x accepted at edge E0, o_valid registered high after E5.
// Backpressure: o_ready only in IDLE; result held in DONE until i_ready.
// Ports: clk, reset_n (async, active-low)
//        i_valid / o_ready / i_x : upstream x stream, Q2.14
//        o_valid / i_ready / o_y : downstream result stream, Q7.25
module horner_seq_ctrl
  import poly_pkg::*;
#(
  parameter int                 WIDTHIN  = 16,
  parameter int                 WIDTHOUT = 32,
  parameter logic [WIDTHIN-1:0] A0       = DEF_A0,
  parameter logic [WIDTHIN-1:0] A1       = DEF_A1,
  parameter logic [WIDTHIN-1:0] A2       = DEF_A2,
  parameter logic [WIDTHIN-1:0] A3       = DEF_A3,
  parameter logic [WIDTHIN-1:0] A4       = DEF_A4,
  parameter logic [WIDTHIN-1:0] A5       = DEF_A5
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [WIDTHIN-1:0]  i_x,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [WIDTHOUT-1:0] o_y
);

  // Innermost Horner term is A5 alone, aligned to the accumulator grid.
  localparam logic [WIDTHOUT-1:0] ACC_INIT =
    {{(WIDTHOUT-WIDTHIN){1'b0}}, A5} << ALIGN_SHIFT;

  state_t               state;
  logic [2:0]           cnt;
  logic [WIDTHOUT-1:0]  acc;
  logic [WIDTHIN-1:0]   x_q;
  logic [WIDTHIN-1:0]   coef;
  logic [WIDTHOUT-1:0]  step_r;

  // Coefficients consumed outermost-last: A4 first, A0 on the final step.
  always_comb begin
    coef = '0;
    case (cnt)
      3'd0:    coef = A4;
      3'd1:    coef = A3;
      3'd2:    coef = A2;
      3'd3:    coef = A1;
      3'd4:    coef = A0;
      default: coef = '0;
    endcase
  end

  horner_step #(
    .WIDTHIN  (WIDTHIN),
    .WIDTHOUT (WIDTHOUT)
  ) u_step (
    .a (acc),
    .x (x_q),
    .c (coef),
    .r (step_r)
  );

  assign o_ready = (state == S_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      acc     <= '0;
      x_q     <= '0;
      o_y     <= '0;
      o_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_valid) begin
            x_q   <= i_x;
            acc   <= ACC_INIT;
            cnt   <= '0;
            state <= S_CALC;
          end
        end

        S_CALC: begin
          if (cnt > CNT_LAST) begin
            // Unreachable counter value: abandon the evaluation silently.
            state   <= S_IDLE;
            cnt     <= '0;
            o_valid <= 1'b0;
          end else begin
            acc <= step_r;
            cnt <= cnt + 3'd1;
            if (cnt == CNT_LAST) begin
              o_y     <= step_r;
              o_valid <= 1'b1;
              state   <= S_DONE;
            end
          end
        end

        S_DONE: begin
          // o_y is left untouched on handoff so it keeps the last result.
          if (i_ready) begin
            o_valid <= 1'b0;
            state   <= S_IDLE;
          end
        end

        default: begin
          state   <= S_IDLE;
          o_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_horner_seq_ctrl.sv
module tb_horner_seq_ctrl;

  logic        clk;
  logic        reset_n;
  logic        i_valid;
  logic        o_ready;
  logic [15:0] i_x;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_y;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [31:0] exp_q[$];

  localparam int WAIT_LIM = 50;

  horner_seq_ctrl dut (
    .clk     (clk),
    .reset_n (reset_n),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_x     (i_x),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_y     (o_y)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Reference Horner evaluation: truncating Q2.14 x Q7.25 product, wrap mod 2^32.
  function automatic logic [31:0] model(input logic [15:0] x);
    logic [31:0] a;
    logic [47:0] p;
    logic [15:0] c [5];
    c = '{16'h02AA, 16'h0AAA, 16'h2000, 16'h4000, 16'h4000};
    a = 32'h0000_0088 << 11;
    for (int i = 0; i < 5; i++) begin
      p = {16'b0, a} * {32'b0, x};
      a = p[45:14] + ({16'b0, c[i]} << 11);
    end
    return a;
  endfunction

  // Present x and hold i_valid until the accepting edge; returns that cycle number.
  task automatic send(input logic [15:0] x, output int acc_cyc);
    int n;
    n = 0;
    i_x     = x;
    i_valid = 1'b1;
    while (!o_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    acc_cyc = cyc;
    i_valid = 1'b0;
  endtask

  // Cycles elapsed (bounded) until o_valid is seen.
  task automatic wait_valid(output int k);
    k = 0;
    while (!o_valid && k < WAIT_LIM) begin
      @(posedge clk); #1;
      k++;
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b1;
    i_x     = 16'h0;
    #2;
    n_checks++;
    if ({o_valid, o_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL reset_flags: o_valid,o_ready=%b required 01", {o_valid, o_ready});
    end
    n_checks++;
    if (o_y !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_o_y: got %h required 00000000", o_y);
    end
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed;
    logic [15:0] xs [3];
    logic [31:0] ys [3];
    logic [31:0] e;
    int a, k;
    xs = '{16'h0000, 16'h4000, 16'h8000};
    ys = '{32'h0200_0000, 32'h056E_E000, 32'h0E87_8000};
    i_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send(xs[i], a);
      exp_q.push_back(ys[i]);
      wait_valid(k);
      n_checks++;
      if (k !== 5) begin
        n_fail++;
        $display("FAIL latency x=%h: got %0d cycles required 5", xs[i], k);
      end
      n_checks++;
      if (o_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL done_ready x=%h: o_ready=%b required 0", xs[i], o_ready);
      end
      e = exp_q.pop_front();
      n_checks++;
      if (o_y !== e) begin
        n_fail++;
        $display("FAIL directed_y x=%h: got %h required %h", xs[i], o_y, e);
      end
      @(posedge clk); #1;
      n_checks++;
      if ({o_valid, o_ready} !== 2'b01) begin
        n_fail++;
        $display("FAIL handoff x=%h: o_valid,o_ready=%b required 01", xs[i], {o_valid, o_ready});
      end
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] e;
    int a, k;
    i_ready = 1'b0;
    send(16'h8000, a);
    exp_q.push_back(32'h0E87_8000);
    wait_valid(k);
    n_checks++;
    if (k !== 5) begin
      n_fail++;
      $display("FAIL bp_latency: got %0d cycles required 5", k);
    end
    e = exp_q.pop_front();
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if ({o_valid, o_ready, o_y} !== {1'b1, 1'b0, e}) begin
        n_fail++;
        $display("FAIL bp_hold cycle %0d: valid=%b ready=%b y=%h required 1 0 %h",
                 i, o_valid, o_ready, o_y, e);
      end
      @(posedge clk); #1;
    end
    i_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({o_valid, o_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL bp_release: o_valid,o_ready=%b required 01", {o_valid, o_ready});
    end
    n_checks++;
    if (o_y !== e) begin
      n_fail++;
      $display("FAIL bp_y_kept: got %h required %h", o_y, e);
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] next_x [3];
    logic [31:0] e;
    int acc_cyc [3];
    int nacc, outs, n;
    logic took;
    next_x = '{16'h8000, 16'h2000, 16'h0000};
    nacc = 0; outs = 0; n = 0;
    i_ready = 1'b1;
    i_x     = 16'h4000;
    i_valid = 1'b1;
    while ((nacc < 3 || exp_q.size() > 0) && n < 100) begin
      took = 1'b0;
      if (o_valid) begin
        outs++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL b2b_unexpected: output %h with nothing pending", o_y);
        end else begin
          e = exp_q.pop_front();
          if (o_y !== e) begin
            n_fail++;
            $display("FAIL b2b_y #%0d: got %h required %h", outs, o_y, e);
          end
        end
      end
      if (i_valid && o_ready) begin
        exp_q.push_back(model(i_x));
        acc_cyc[nacc] = cyc;
        nacc++;
        took = 1'b1;
      end
      @(posedge clk); #1;
      n++;
      // New x appears while the block is busy; it must not be captured.
      if (took) begin
        i_x = next_x[nacc-1];
        if (nacc == 3) i_valid = 1'b0;
      end
    end
    i_valid = 1'b0;
    n_checks++;
    if (nacc !== 3 || outs !== 3) begin
      n_fail++;
      $display("FAIL b2b_count: accepts=%0d outputs=%0d required 3 3", nacc, outs);
    end else begin
      for (int i = 1; i < 3; i++) begin
        n_checks++;
        if (acc_cyc[i] - acc_cyc[i-1] !== 7) begin
          n_fail++;
          $display("FAIL b2b_spacing %0d: got %0d cycles required 7", i,
                   acc_cyc[i] - acc_cyc[i-1]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_calc;
    logic [31:0] e;
    int a, k;
    i_ready = 1'b1;
    send(16'h8000, a);
    @(posedge clk); #1;
    @(posedge clk); #1;
    // Evaluation is now on its third step (cnt == 2).
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({o_valid, o_ready, o_y} !== {1'b0, 1'b1, 32'h0}) begin
      n_fail++;
      $display("FAIL mid_reset: valid=%b ready=%b y=%h required 0 1 00000000",
               o_valid, o_ready, o_y);
    end
    #2 reset_n = 1'b1;
    @(posedge clk); #1;
    send(16'h4000, a);
    exp_q.push_back(32'h056E_E000);
    wait_valid(k);
    n_checks++;
    if (k !== 5) begin
      n_fail++;
      $display("FAIL post_reset_latency: got %0d cycles required 5", k);
    end
    e = exp_q.pop_front();
    n_checks++;
    if (o_y !== e) begin
      n_fail++;
      $display("FAIL post_reset_y: got %h required %h", o_y, e);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random;
    logic [15:0] edge_x [4];
    logic [31:0] e;
    int sent, cycles;
    logic took;
    edge_x = '{16'hFFFF, 16'hC000, 16'h0001, 16'h7FFF};
    sent = 0; cycles = 0; took = 1'b0;
    i_valid = 1'b0;
    while ((sent < 1000 || exp_q.size() > 0) && cycles < 30000) begin
      i_ready = ($urandom_range(0, 3) != 0);
      if (!i_valid || took) begin
        i_valid = (sent < 1000) && ($urandom_range(0, 3) != 0);
        i_x     = (sent < 4) ? edge_x[sent] : 16'($urandom);
      end
      took = 1'b0;
      if (o_valid && i_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL rand_unexpected: output %h with nothing pending", o_y);
        end else begin
          e = exp_q.pop_front();
          if (o_y !== e) begin
            n_fail++;
            $display("FAIL rand_y: got %h required %h", o_y, e);
          end
        end
      end
      if (i_valid && o_ready) begin
        exp_q.push_back(model(i_x));
        sent++;
        took = 1'b1;
      end
      @(posedge clk); #1;
      cycles++;
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    n_checks++;
    if (sent !== 1000 || exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL rand_drain: sent=%0d pending=%0d required 1000 0", sent, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_calc();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
